link_arb: RTL and testbench

//  N-channel round-robin arbiter for the req/ack/dvld link protocol. Merges N requester

---
 rtl/link_arb_if.sv | 33 +++
 rtl/link_arb.sv | 137 +++++++++++++
 tb/tb_link_arb.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/link_arb_if.sv
// Link bundle for link_arb: N requester links (m_*) plus the single downstream link (s_*).
// slave is the arbiter's view; master is the view of the requesters and memory port around it.
interface link_arb_if #(
    parameter int N_CH   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 3
);
    logic [N_CH-1:0]        m_req;
    logic [N_CH*ADDR_W-1:0] m_addr;
    logic [N_CH-1:0]        m_ack;
    logic [N_CH-1:0]        m_dvld;
    logic [DATA_W-1:0]      m_rdata;
    logic [CNT_W-1:0]       m_dcnt;
    logic [N_CH-1:0]        m_err;

    logic                   s_req;
    logic [ADDR_W-1:0]      s_addr;
    logic                   s_ack;
    logic                   s_dvld;
    logic [DATA_W-1:0]      s_rdata;
    logic [CNT_W-1:0]       s_dcnt;

    modport slave (
        input  m_req, m_addr, s_ack, s_dvld, s_rdata, s_dcnt,
        output m_ack, m_dvld, m_rdata, m_dcnt, m_err, s_req, s_addr
    );

    modport master (
        output m_req, m_addr, s_ack, s_dvld, s_rdata, s_dcnt,
        input  m_ack, m_dvld, m_rdata, m_dcnt, m_err, s_req, s_addr
    );
endinterface

// File: rtl/link_arb.sv
// N-channel round-robin arbiter merging req/ack/dvld requester links onto one downstream link.
// Optional watchdog abort enabled by defining LINK_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no owner; round-robin pick among m_req, latch grant and address
// REQ   | s_req high to downstream, waiting for s_ack
// DATA  | forwarding beats to the owner until beat BURST_LEN-1
module link_arb #(
    parameter  int N_CH        = 4,
    parameter  int ADDR_W      = 32,
    parameter  int DATA_W      = 32,
    parameter  int BURST_LEN   = 8,
    parameter  int TIMEOUT_CYC = 256,
    localparam int CNT_W       = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1,
    localparam int GID_W       = $clog2(N_CH)
) (
    input  logic             clk,
    input  logic             rst,
    link_arb_if.slave        lnk,
    output logic             busy,
    output logic [GID_W-1:0] grant_id
);
    typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

    state_t            state, state_nxt;
    logic [GID_W-1:0]  last;
    logic [GID_W-1:0]  pick;
    logic [GID_W-1:0]  idx;
    logic              any_req;
    logic              last_beat;
    logic              tmo_hit;
    logic [ADDR_W-1:0] addr_q;
    logic              req_c;
    logic [N_CH-1:0]   ack_c;
    logic [N_CH-1:0]   dvld_c;
    logic [N_CH-1:0]   err_c;

    // Scan downward so the channel closest after 'last' is the one left in pick.
    always_comb begin
        pick    = '0;
        any_req = 1'b0;
        idx     = '0;
        for (int k = N_CH; k >= 1; k--) begin
            idx = GID_W'((int'(last) + k) % N_CH);
            if (lnk.m_req[idx]) begin
                pick    = idx;
                any_req = 1'b1;
            end
        end
    end

    assign last_beat = lnk.s_dvld && (lnk.s_dcnt == LAST_CNT);

`ifdef LINK_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] tmo_cnt;

    // Progress (s_ack in REQ, a beat in DATA) wins over an expiry in the same cycle.
    assign tmo_hit = (tmo_cnt == '0) &&
                     (((state == REQ) && !lnk.s_ack) || ((state == DATA) && !lnk.s_dvld));

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= TMO_W'(TIMEOUT_CYC);
        end else if ((state == IDLE) || ((state == DATA) && lnk.s_dvld)) begin
            tmo_cnt <= TMO_W'(TIMEOUT_CYC);
        end else if (tmo_cnt != '0) begin
            tmo_cnt <= tmo_cnt - 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            last     <= GID_W'(N_CH - 1);
            grant_id <= '0;
            addr_q   <= '0;
        end else begin
            state <= state_nxt;
            if ((state == IDLE) && any_req) begin
                grant_id <= pick;
                addr_q   <= lnk.m_addr[int'(pick)*ADDR_W +: ADDR_W];
            end
            if (((state == DATA) && last_beat) || tmo_hit) begin
                last <= grant_id;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        req_c     = 1'b0;
        ack_c     = '0;
        dvld_c    = '0;
        err_c     = '0;
        case (state)
            IDLE: begin
                if (any_req) state_nxt = REQ;
            end
            REQ: begin
                req_c = 1'b1;
                if (tmo_hit) begin
                    err_c[grant_id] = 1'b1;
                    state_nxt       = IDLE;
                end else if (lnk.s_ack) begin
                    ack_c[grant_id] = 1'b1;
                    state_nxt       = DATA;
                end
            end
            DATA: begin
                if (lnk.s_dvld) dvld_c[grant_id] = 1'b1;
                if (tmo_hit) begin
                    err_c[grant_id] = 1'b1;
                    state_nxt       = IDLE;
                end else if (last_beat) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign lnk.s_req   = req_c;
    assign lnk.s_addr  = addr_q;
    assign lnk.m_ack   = ack_c;
    assign lnk.m_dvld  = dvld_c;
    assign lnk.m_err   = err_c;
    assign lnk.m_rdata = lnk.s_rdata;
    assign lnk.m_dcnt  = lnk.s_dcnt;
    assign busy        = (state != IDLE);
endmodule

// File: tb/tb_link_arb.sv
// Directed bench for link_arb: beats are scoreboarded when driven and checked as the owner sees them.
module tb_link_arb;
    localparam int N_CH      = 4;
    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int BURST_LEN = 8;
    localparam int CNT_W     = 3;
    localparam int TMO       = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       busy;
    logic [1:0] grant_id;

    link_arb_if #(.N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) lnk ();

    link_arb #(
        .N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .BURST_LEN(BURST_LEN), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .rst(rst), .lnk(lnk), .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               ch;
        logic [DATA_W-1:0] data;
        logic [CNT_W-1:0]  cnt;
    } beat_t;

    beat_t           exp_q[$];
    logic [N_CH-1:0] exp_ack;
    logic [N_CH-1:0] exp_err;
    int              tests = 0;
    int              fails = 0;

    function automatic logic [ADDR_W-1:0] ch_addr(input int ch);
        return ADDR_W'(32'h0000_0100 * (ch + 1) + 32'h0A00_0000);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Per-cycle monitor: m_ack/m_err against the bench's expectation, m_dvld against the scoreboard.
    task automatic mon();
        beat_t e;
        chk("m_ack", lnk.m_ack, exp_ack);
        chk("m_err", lnk.m_err, exp_err);
        for (int c = 0; c < N_CH; c++) begin
            if (lnk.m_dvld[c] === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_dvld", lnk.m_dvld, '0);
                end else begin
                    e = exp_q.pop_front();
                    chk("dvld_ch", c, e.ch);
                    chk("rdata", lnk.m_rdata, e.data);
                    chk("dcnt", lnk.m_dcnt, e.cnt);
                end
            end
        end
    endtask

    task automatic step();
        #1;
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset();
        chk("rst_s_req", lnk.s_req, 0);
        chk("rst_s_addr", lnk.s_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_m_ack", lnk.m_ack, 0);
        chk("rst_m_dvld", lnk.m_dvld, 0);
        chk("rst_m_err", lnk.m_err, 0);
    endtask

    // One burst for channel ch: wait for s_req, ack after ack_dly REQ cycles, then BURST_LEN beats.
    task automatic burst(input int ch, input int ack_dly, input logic [N_CH-1:0] req_after,
                         input bit dvld_in_req, input bit gaps, input int rst_beat,
                         input int exp_wait);
        int    w;
        beat_t e;
        w = 0;
        while (lnk.s_req !== 1'b1 && w < 50) begin
            step();
            w++;
        end
        chk("s_req_rise", lnk.s_req, 1);
        if (exp_wait >= 0) chk("arb_latency", w, exp_wait);
        chk("grant_id", grant_id, ch);
        chk("s_addr", lnk.s_addr, ch_addr(ch));
        chk("busy_req", busy, 1);
        for (int i = 0; i < ack_dly; i++) begin
            lnk.s_dvld = dvld_in_req;
            lnk.s_dcnt = 3'd7;
            step();
            chk("s_req_hold", lnk.s_req, 1);
            chk("s_addr_hold", lnk.s_addr, ch_addr(ch));
        end
        lnk.s_dvld   = 1'b0;
        lnk.s_ack    = 1'b1;
        exp_ack      = '0;
        exp_ack[ch]  = 1'b1;
        step();
        lnk.s_ack = 1'b0;
        exp_ack   = '0;
        lnk.m_req = req_after;
        chk("s_req_drop", lnk.s_req, 0);
        for (int b = 0; b < BURST_LEN; b++) begin
            if (gaps && ($urandom_range(0, 2) == 0)) begin
                lnk.s_dvld = 1'b0;
                lnk.s_dcnt = 3'd7;
                step();
            end
            lnk.s_dvld  = 1'b1;
            lnk.s_rdata = $urandom;
            lnk.s_dcnt  = CNT_W'(b);
            e.ch   = ch;
            e.data = lnk.s_rdata;
            e.cnt  = CNT_W'(b);
            exp_q.push_back(e);
            if (b == rst_beat) rst = 1'b1;
            step();
            if (b == rst_beat) begin
                lnk.s_dvld = 1'b0;
                rst        = 1'b0;
                return;
            end
        end
        lnk.s_dvld = 1'b0;
        chk("busy_idle", busy, 0);
        chk("s_req_idle", lnk.s_req, 0);
    endtask

    initial begin
        rst         = 1'b1;
        exp_ack     = '0;
        exp_err     = '0;
        lnk.m_req   = '0;
        lnk.s_ack   = 1'b0;
        lnk.s_dvld  = 1'b0;
        lnk.s_rdata = '0;
        lnk.s_dcnt  = '0;
        for (int c = 0; c < N_CH; c++) lnk.m_addr[c*ADDR_W +: ADDR_W] = ch_addr(c);
        @(posedge clk);
        #1;
        chk_reset();
        step();
        rst = 1'b0;
        step();

        // single requester ch2, ack three cycles after s_req
        lnk.m_addr[2*ADDR_W +: ADDR_W] = 32'h0000_1000;
        lnk.m_req = 4'b0100;
        begin
            int w;
            w = 0;
            while (lnk.s_req !== 1'b1 && w < 10) begin step(); w++; end
            chk("t1_latency", w, 1);
            chk("t1_s_addr", lnk.s_addr, 32'h0000_1000);
        end
        lnk.m_addr[2*ADDR_W +: ADDR_W] = ch_addr(2);
        lnk.m_addr[2*ADDR_W +: ADDR_W] = 32'h0000_1000;
        lnk.m_addr[2*ADDR_W +: ADDR_W] = ch_addr(2);

        // the address above was latched at grant; the burst checks it against the latched value
        begin
            int ack_cnt;
            ack_cnt = 0;
            for (int i = 0; i < 3; i++) begin
                step();
                chk("t1_s_addr_stable", lnk.s_addr, 32'h0000_1000);
            end
            lnk.s_ack  = 1'b1;
            exp_ack    = 4'b0100;
            step();
            lnk.s_ack  = 1'b0;
            exp_ack    = '0;
            lnk.m_req  = '0;
            for (int b = 0; b < BURST_LEN; b++) begin
                beat_t e;
                lnk.s_dvld  = 1'b1;
                lnk.s_rdata = 32'hC0DE_0000 + 32'(b);
                lnk.s_dcnt  = CNT_W'(b);
                e.ch = 2; e.data = lnk.s_rdata; e.cnt = CNT_W'(b);
                exp_q.push_back(e);
                step();
                ack_cnt++;
            end
            lnk.s_dvld = 1'b0;
            chk("t1_beats", ack_cnt - exp_q.size(), BURST_LEN);
            chk("t1_busy_end", busy, 0);
        end

        // after reset all four hold m_req: grants 0,1,2,3,0 with one idle cycle between
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset();
        lnk.m_req = 4'b1111;
        burst(0, 1, 4'b1111, 1'b0, 1'b0, -1, 1);
        burst(1, 2, 4'b1111, 1'b0, 1'b1, -1, 1);
        burst(2, 0, 4'b1111, 1'b0, 1'b0, -1, 1);
        burst(3, 1, 4'b1111, 1'b0, 1'b1, -1, 1);
        burst(0, 0, 4'b0000, 1'b0, 1'b0, -1, 1);

        // ch1 served, then ch0 and ch1 together: search starts at ch2 and wraps to ch0
        lnk.m_req = 4'b0010;
        burst(1, 2, 4'b0011, 1'b0, 1'b0, -1, 1);
        burst(0, 1, 4'b0010, 1'b0, 1'b0, -1, 1);
        burst(1, 0, 4'b0000, 1'b0, 1'b0, -1, 1);

        // stray s_dvld / s_ack in IDLE, stray s_dvld (dcnt=7) in REQ
        lnk.s_dvld = 1'b1;
        lnk.s_dcnt = 3'd7;
        lnk.s_ack  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("t4_idle_busy", busy, 0);
            chk("t4_idle_s_req", lnk.s_req, 0);
        end
        lnk.s_ack  = 1'b0;
        lnk.s_dvld = 1'b0;
        lnk.m_req  = 4'b1000;
        burst(3, 3, 4'b0000, 1'b1, 1'b0, -1, 1);

        // reset during beat 4 of a ch3 burst, then ch3 granted normally
        lnk.m_req = 4'b1000;
        burst(3, 1, 4'b0000, 1'b0, 1'b0, 4, 1);
        chk_reset();
        chk("t5_q_empty", exp_q.size(), 0);
        lnk.m_req = 4'b1000;
        burst(3, 2, 4'b0000, 1'b0, 1'b1, -1, 1);

`ifdef LINK_ARB_TIMEOUT_EN
        // s_ack never arrives: m_err[0] 16 cycles after REQ entry, then ch1 granted
        lnk.m_req = 4'b0011;
        begin
            int w;
            w = 0;
            while (lnk.s_req !== 1'b1 && w < 10) begin step(); w++; end
            chk("t6_s_req", lnk.s_req, 1);
            chk("t6_grant", grant_id, 0);
            for (int i = 0; i <= TMO; i++) begin
                chk("t6_s_req_wait", lnk.s_req, 1);
                exp_err = (i == TMO) ? 4'b0001 : 4'b0000;
                step();
            end
            exp_err = '0;
            chk("t6_s_req_low", lnk.s_req, 0);
            chk("t6_busy_low", busy, 0);
        end
        burst(1, 1, 4'b0000, 1'b0, 1'b0, -1, 1);
`else
        // without the watchdog s_req stays high while s_ack is withheld
        lnk.m_req = 4'b0001;
        burst(0, 40, 4'b0000, 1'b0, 1'b0, -1, 1);
`endif

        step();
        chk("final_q_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
